// File: rtl/dest_sequencer.sv
// Mission sequencer: walks a captured destination list, issuing each
// waypoint to navigation, dwelling on arrival, then returning home.
module dest_sequencer #(
  parameter int          N_SLOTS      = 6,
  parameter int          DWELL_CYCLES = 16,
  parameter logic [7:0]  HOME_X       = 8'h06,
  parameter logic [7:0]  HOME_Y       = 8'h06
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [16*N_SLOTS-1:0]  destn_in,
  input  logic                   load,
  input  logic                   start,
  input  logic                   abort,
  output logic [7:0]             goal_x,
  output logic [7:0]             goal_y,
  output logic                   goal_valid,
  input  logic                   goal_ready,
  input  logic                   arrived,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             wp_idx,
  output logic [2:0]             wp_count
);

  localparam int CW = $clog2(DWELL_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_ARR, DWELL, HOME_ISSUE, HOME_WAIT, DONE
  } state_t;

  state_t                 state;
  logic [16*N_SLOTS-1:0]  list;
  logic [CW-1:0]          cnt;
  logic                   abort_pend;
  logic [2:0]             nxt_idx;
  logic [15:0]            nxt_slot;
  logic [15:0]            first_slot;

  // The first all-zero pair terminates the list.
  function automatic logic [2:0] count_valid(
    input logic [16*N_SLOTS-1:0] d
  );
    logic [2:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (run && d[16*k +: 16] != 16'h0)
        n = n + 3'd1;
      else
        run = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [15:0] slot(
    input logic [16*N_SLOTS-1:0] d,
    input logic [2:0]            idx
  );
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < N_SLOTS; k++)
      if (3'(k) == idx) s = d[16*k +: 16];
    return s;
  endfunction

  always_comb begin
    nxt_idx    = wp_idx + 3'd1;
    nxt_slot   = slot(list, nxt_idx);
    first_slot = slot(list, 3'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      list       <= '0;
      goal_x     <= '0;
      goal_y     <= '0;
      goal_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wp_idx     <= '0;
      wp_count   <= '0;
      cnt        <= '0;
      abort_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            list     <= destn_in;
            wp_count <= count_valid(destn_in);
          end else if (start && wp_count != 3'd0) begin
            state      <= ISSUE;
            wp_idx     <= '0;
            goal_x     <= first_slot[7:0];
            goal_y     <= first_slot[15:8];
            goal_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ISSUE: begin
          if (goal_valid && goal_ready) begin
            goal_valid <= 1'b0;
            if (abort_pend || abort) begin
              state      <= HOME_ISSUE;
              abort_pend <= 1'b0;
            end else begin
              state <= WAIT_ARR;
            end
          end else if (abort) begin
            abort_pend <= 1'b1;
          end
        end
        WAIT_ARR: begin
          if (abort) begin
            state      <= HOME_ISSUE;
            goal_x     <= HOME_X;
            goal_y     <= HOME_Y;
            goal_valid <= 1'b1;
            abort_pend <= 1'b0;
          end else if (arrived) begin
            state <= DWELL;
            cnt   <= CW'(DWELL_CYCLES - 1);
          end
        end
        DWELL: begin
          if (abort || (cnt == '0 && nxt_idx >= wp_count)) begin
            state      <= HOME_ISSUE;
            goal_x     <= HOME_X;
            goal_y     <= HOME_Y;
            goal_valid <= 1'b1;
            abort_pend <= 1'b0;
          end else if (cnt == '0) begin
            state      <= ISSUE;
            wp_idx     <= nxt_idx;
            goal_x     <= nxt_slot[7:0];
            goal_y     <= nxt_slot[15:8];
            goal_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOME_ISSUE: begin
          // Arriving here from an accepted aborted goal leaves valid low
          // for one cycle before the home goal is offered.
          if (!goal_valid) begin
            goal_x     <= HOME_X;
            goal_y     <= HOME_Y;
            goal_valid <= 1'b1;
          end else if (goal_ready) begin
            goal_valid <= 1'b0;
            state      <= HOME_WAIT;
          end
        end
        HOME_WAIT: begin
          if (arrived) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dest_sequencer.sv
// Directed bench for dest_sequencer: mission flow, backpressure,
// list termination, abort paths and asynchronous reset.
module tb_dest_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] destn_in;
  logic        load, start, abort;
  logic [7:0]  goal_x, goal_y;
  logic        goal_valid, goal_ready, arrived;
  logic        busy, done;
  logic [2:0]  wp_idx, wp_count;

  int ncmp = 0;
  int nfail = 0;
  int n;

  dest_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .destn_in   (destn_in),
    .load       (load),
    .start      (start),
    .abort      (abort),
    .goal_x     (goal_x),
    .goal_y     (goal_y),
    .goal_valid (goal_valid),
    .goal_ready (goal_ready),
    .arrived    (arrived),
    .busy       (busy),
    .done       (done),
    .wp_idx     (wp_idx),
    .wp_count   (wp_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Goal is offered; accept it, arrive 2 cycles later, time the dwell.
  task automatic do_wp(input logic [7:0] x,
                       input logic [7:0] y,
                       input logic [2:0] idx);
    chk("wp_valid", {31'b0, goal_valid}, 1);
    chk("wp_x", {24'b0, goal_x}, {24'b0, x});
    chk("wp_y", {24'b0, goal_y}, {24'b0, y});
    chk("wp_idx", {29'b0, wp_idx}, {29'b0, idx});
    tick();
    chk("wp_acc", {31'b0, goal_valid}, 0);
    tick();
    arrived = 1'b1;
    tick();
    arrived = 1'b0;
    n = 0;
    while (!goal_valid && n < 40) begin
      tick();
      n++;
    end
    chk("dwell_len", n, 16);
  endtask

  task automatic do_home();
    chk("home_valid", {31'b0, goal_valid}, 1);
    chk("home_x", {24'b0, goal_x}, 32'h06);
    chk("home_y", {24'b0, goal_y}, 32'h06);
    tick();
    chk("home_acc", {31'b0, goal_valid}, 0);
    tick();
    arrived = 1'b1;
    tick();
    arrived = 1'b0;
    chk("done_pulse", {31'b0, done}, 1);
    chk("busy_done", {31'b0, busy}, 1);
    tick();
    chk("done_clr", {31'b0, done}, 0);
    chk("busy_idle", {31'b0, busy}, 0);
  endtask

  initial begin
    rst = 1'b1;
    destn_in = '0;
    load = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    goal_ready = 1'b0;
    arrived = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'b0, goal_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_gx", {24'b0, goal_x}, 0);
    chk("rst_cnt", {29'b0, wp_count}, 0);
    rst = 1'b0;
    tick();

    // Three-slot mission, ready tied high
    destn_in = {48'h0, 16'h3052, 16'h3022, 16'h3006};
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("cnt3", {29'b0, wp_count}, 3);
    goal_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start", {31'b0, busy}, 1);
    do_wp(8'h06, 8'h30, 3'd0);
    do_wp(8'h22, 8'h30, 3'd1);
    do_wp(8'h52, 8'h30, 3'd2);
    do_home();

    // Backpressure, ignored load/start/arrived while busy, abort in DWELL
    goal_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      arrived = (i == 3);
      load = (i == 5);
      start = (i == 5);
      destn_in = (i == 5) ? {96{1'b1}} : destn_in;
      tick();
      chk("bp_valid", {31'b0, goal_valid}, 1);
      chk("bp_goal", {16'b0, goal_y, goal_x}, 32'h3006);
    end
    arrived = 1'b0;
    load = 1'b0;
    start = 1'b0;
    goal_ready = 1'b1;
    tick();
    chk("bp_acc", {31'b0, goal_valid}, 0);
    chk("bp_cnt", {29'b0, wp_count}, 3);
    tick();
    arrived = 1'b1;
    tick();
    arrived = 1'b0;
    n = 0;
    while (!goal_valid && n < 40) begin
      tick();
      n++;
    end
    chk("bp_dwell", n, 16);
    chk("bp_wp1", {16'b0, goal_y, goal_x}, 32'h3022);
    tick();
    tick();
    arrived = 1'b1;
    tick();
    arrived = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_dw_idx", {29'b0, wp_idx}, 1);
    do_home();

    // Abort while goal is held in ISSUE
    goal_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_is_hold", {16'b0, goal_y, goal_x}, 32'h3006);
    chk("ab_is_valid", {31'b0, goal_valid}, 1);
    goal_ready = 1'b1;
    tick();
    chk("ab_is_acc", {31'b0, goal_valid}, 0);
    tick();
    do_home();

    // Reset in WAIT_ARR
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("wa_valid", {31'b0, goal_valid}, 0);
    chk("wa_busy", {31'b0, busy}, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy", {31'b0, busy}, 0);
    chk("ar_gx", {24'b0, goal_x}, 0);
    chk("ar_cnt", {29'b0, wp_count}, 0);
    tick();
    rst = 1'b0;

    // Empty list and start ignored
    destn_in = '0;
    load = 1'b1;
    tick();
    load = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("empty_busy", {31'b0, busy}, 0);
    chk("empty_valid", {31'b0, goal_valid}, 0);

    // Terminated list; load wins over simultaneous start
    destn_in = {48'h0, 16'h3052, 16'h0000, 16'h3006};
    load = 1'b1;
    start = 1'b1;
    tick();
    load = 1'b0;
    start = 1'b0;
    chk("ls_busy", {31'b0, busy}, 0);
    chk("term_cnt", {29'b0, wp_count}, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    do_wp(8'h06, 8'h30, 3'd0);
    chk("term_idx", {29'b0, wp_idx}, 0);
    do_home();

    // Full six-slot list
    destn_in = {16'h90a6, 16'h80a5, 16'h70a4,
                16'h60a3, 16'h50a2, 16'h40a1};
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("cnt6", {29'b0, wp_count}, 6);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++)
      do_wp(8'ha1 + 8'(k), 8'h40 + 8'(16 * k), 3'(k));
    chk("full_idx", {29'b0, wp_idx}, 5);
    do_home();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
